uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Far end of the UART link: parses command frames from the UART receiver's parallel output and executes them.
//  Drives the register file and ALU, then returns response bytes through the UART transmitter's parallel input.
//  Sits between the UART RX/TX pair and the register file / ALU, entirely in the system clock domain.
//  Handshake inputs (rx_d_valid, tx_busy) arrive already synchronised to clk; CDC is outside this block.
// PARAMETERS
//  DATA_W    8    UART byte width; register data width
//  ADDR_W    4    register file address width; low ADDR_W bits of the address byte are used
//  FUN_W     4    ALU function width; low FUN_W bits of the function byte are used
//  TIMEOUT   1024 idle cycles before a partial frame is aborted (used only with the timeout feature)
// PORTS
//  clk              in   1          system clock
//  rst              in   1          asynchronous, active-low reset
//  rx_p_data        in   DATA_W     received byte
//  rx_d_valid       in   1          1-cycle strobe: rx_p_data is valid
//  rx_par_error     in   1          parity error qualifier, sampled with rx_d_valid
//  rx_framing_error in   1          framing error qualifier, sampled with rx_d_valid
//  rf_addr          out  ADDR_W     register file address
//  rf_wr_en         out  1          1-cycle write strobe
//  rf_wr_data       out  DATA_W     register file write data
//  rf_rd_en         out  1          1-cycle read strobe
//  rf_rd_data       in   DATA_W     register file read data
//  rf_rd_valid      in   1          read data valid
//  alu_en           out  1          1-cycle ALU start strobe
//  alu_fun          out  FUN_W      ALU function select
//  alu_out          in   2*DATA_W   ALU result
//  alu_out_valid    in   1          ALU result valid
//  tx_p_data        out  DATA_W     byte to transmit
//  tx_d_valid       out  1          1-cycle transmit request
//  tx_busy          in   1          transmitter busy
//  cmd_error        out  1          1-cycle pulse: frame aborted or byte dropped
// BEHAVIOUR
//  Reset: all outputs, including tx_p_data and rf_wr_data, are 0. FSM is in IDLE; capture registers are 0.
//  Reset mid-frame discards the frame immediately, with no further strobes.
//  Opcodes (IDLE only):
//   0xAA wr: addr byte, then data byte -> rf_wr_en pulse
//   0xBB rd: addr byte -> response of 1 byte
//   0xCC alu: A byte, then B byte, then fun byte -> response of 2 bytes
//   0xDD alu_nop: fun byte -> response of 2 bytes
//  Any other byte in IDLE is ignored: no cmd_error, FSM stays in IDLE.
//  FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND, TX_HOLD.
//  Write: rf_addr is latched on the addr byte. The cycle after the data byte, rf_wr_en=1 with rf_wr_data set; FSM returns to IDLE.
//  0xCC: operand A is written to address 0 and B to address 1. Each write issues its rf_wr_en the cycle after that byte.
//  Read: rf_rd_en pulses the cycle after the addr byte. FSM holds in RD_WAIT until rf_rd_valid, captures rf_rd_data, then goes to TX_SEND with a count of 1.
//  ALU: alu_en pulses for 1 cycle with alu_fun the cycle after the fun byte.
//   FSM holds in ALU_WAIT until alu_out_valid, captures alu_out, then sends LSB first, then MSB.
//  TX_SEND: while tx_busy=0, assert tx_d_valid for 1 cycle with tx_p_data; go to TX_HOLD.
//   tx_p_data stays stable until the next send.
//  TX_HOLD: wait for tx_busy to rise, then fall. Then send the next byte, or return to IDLE after the last byte.
//  A byte with rx_par_error or rx_framing_error set is never used.
//   In IDLE it is dropped silently. Mid-frame it aborts the frame: cmd_error pulses and FSM goes to IDLE. Writes already issued stand.
//  rx_d_valid in RD_WAIT / ALU_WAIT / TX_* drops the byte (no buffering) and pulses cmd_error; the operation continues.
//  rf_rd_valid and alu_out_valid are ignored outside their wait states.
// CONFIGURATION
//  UART_CMD_TIMEOUT_EN defined: a cycle counter runs in the byte-wait states (WR_*, RD_ADDR, ALU_A/B/FUN).
//   It clears on every rx_d_valid.
//   After TIMEOUT cycles with no byte: cmd_error pulses and FSM goes to IDLE.
//  Macro undefined: no counter; a partial frame waits indefinitely.
// STRUCTURE
//  Package uart_cmd_pkg: opcode constants (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU=8'hCC, CMD_ALU_NOP=8'hDD), FSM state enum.
//  Sub-module uart_resp_tx: 1/2-byte response sequencer covering the TX_SEND/TX_HOLD busy handshake.
//   Inputs: start, count, 16-bit word. Output: done.
// TESTING
//  AA,05,3C -> one rf_wr_en, rf_addr=5, rf_wr_data=0x3C; no tx_d_valid.
//  BB,05, rf_rd_data=0x3C one cycle after rf_rd_en -> exactly one tx_d_valid, tx_p_data=0x3C.
//  CC,07,03,00, alu_out=0x000A -> writes 0x07 to address 0 and 0x03 to address 1; alu_fun=0.
//   Then tx 0x0A, 0x00 in order; second byte only after tx_busy falls.
//  AA,05 then byte 0x11 with rx_par_error -> cmd_error pulse, no write; next AA,02,FF writes 0xFF to address 2.
//  BB,01 with tx_busy held high 50 cycles -> tx_d_valid held off until tx_busy=0; byte arriving meanwhile -> cmd_error, byte dropped.
//  With UART_CMD_TIMEOUT_EN and TIMEOUT=16: AA,05 then silence -> cmd_error at 16 idle cycles, FSM in IDLE.
//   Without the macro -> no cmd_error.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcode constants and FSM state encoding shared by the command responder
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU     = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FUN,
        ALU_WAIT,
        TX_SEND,
        TX_HOLD
    } state_t;

endpackage

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: sends a 1- or 2-byte response LSB first using the transmitter busy handshake
module uart_resp_tx
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          count,
    input  logic [2*DATA_W-1:0] word,
    input  logic                tx_busy,
    output logic [DATA_W-1:0]   tx_p_data,
    output logic                tx_d_valid,
    output logic                done
);

    state_t              state, state_d;
    logic [2*DATA_W-1:0] sh, sh_d;
    logic [1:0]          rem, rem_d;
    logic                seen, seen_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d, done_d;

    // state, shift register and registered transmitter outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sh         <= '0;
            rem        <= '0;
            seen       <= 1'b0;
            tx_p_data  <= '0;
            tx_d_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            sh         <= sh_d;
            rem        <= rem_d;
            seen       <= seen_d;
            tx_p_data  <= data_d;
            tx_d_valid <= valid_d;
            done       <= done_d;
        end
    end

    // send once the line is free, then wait for busy to rise and fall before the next byte
    always_comb begin
        state_d = state;
        sh_d    = sh;
        rem_d   = rem;
        seen_d  = seen;
        data_d  = tx_p_data;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: if (start) begin
                sh_d    = word;
                rem_d   = count;
                state_d = TX_SEND;
            end
            TX_SEND: if (!tx_busy) begin
                valid_d = 1'b1;
                data_d  = sh[DATA_W-1:0];
                seen_d  = 1'b0;
                state_d = TX_HOLD;
            end
            TX_HOLD: begin
                seen_d = seen | tx_busy;
                if (seen && !tx_busy) begin
                    rem_d   = rem - 2'd1;
                    sh_d    = sh >> DATA_W;
                    done_d  = rem < 2'd2;
                    state_d = done_d ? IDLE : TX_SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses UART command frames, drives register file / ALU, returns responses (optional UART_CMD_TIMEOUT_EN)
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int FUN_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   rx_p_data,
    input  logic                rx_d_valid,
    input  logic                rx_par_error,
    input  logic                rx_framing_error,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic                rf_wr_en,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic                rf_rd_en,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic                rf_rd_valid,
    output logic                alu_en,
    output logic [FUN_W-1:0]    alu_fun,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_out_valid,
    output logic [DATA_W-1:0]   tx_p_data,
    output logic                tx_d_valid,
    input  logic                tx_busy,
    output logic                cmd_error
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [FUN_W-1:0]    fun_d;
    logic                wr_d, rd_d, alu_d, err_d;
    logic                tx_start, tx_done;
    logic [1:0]          tx_count;
    logic [2*DATA_W-1:0] tx_word;
    logic                good, bad, byte_wait, tmo, abort;

    assign good      = rx_d_valid && !rx_par_error && !rx_framing_error;
    assign bad       = rx_d_valid && (rx_par_error || rx_framing_error);
    assign byte_wait = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};
    assign abort     = byte_wait && (bad || tmo);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo = byte_wait && !rx_d_valid && tmo_cnt == TW'(TIMEOUT - 1);

    // idle-cycle counter for partial frames, cleared by any incoming byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_cnt <= '0;
        else tmo_cnt <= (byte_wait && !rx_d_valid) ? tmo_cnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    // state and registered register-file / ALU / error outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            state      <= state_d;
            rf_addr    <= addr_d;
            rf_wr_data <= wdata_d;
            alu_fun    <= fun_d;
            rf_wr_en   <= wr_d;
            rf_rd_en   <= rd_d;
            alu_en     <= alu_d;
            cmd_error  <= err_d;
        end
    end

    // frame parser: decode opcode, collect operands, wait for results and hand them to the sender
    always_comb begin
        state_d  = state;
        addr_d   = rf_addr;
        wdata_d  = rf_wr_data;
        fun_d    = alu_fun;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        alu_d    = 1'b0;
        err_d    = 1'b0;
        tx_start = 1'b0;
        tx_count = 2'd1;
        tx_word  = {{DATA_W{1'b0}}, rf_rd_data};
        if (abort) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (good)
                    state_d = rx_p_data == DATA_W'(CMD_WR)      ? WR_ADDR :
                              rx_p_data == DATA_W'(CMD_RD)      ? RD_ADDR :
                              rx_p_data == DATA_W'(CMD_ALU)     ? ALU_A   :
                              rx_p_data == DATA_W'(CMD_ALU_NOP) ? ALU_FUN : IDLE;
                WR_ADDR: if (good) begin
                    addr_d  = rx_p_data[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
                WR_DATA: if (good) begin
                    wdata_d = rx_p_data;
                    wr_d    = 1'b1;
                    state_d = IDLE;
                end
                RD_ADDR: if (good) begin
                    addr_d  = rx_p_data[ADDR_W-1:0];
                    rd_d    = 1'b1;
                    state_d = RD_WAIT;
                end
                ALU_A: if (good) begin
                    addr_d  = '0;
                    wdata_d = rx_p_data;
                    wr_d    = 1'b1;
                    state_d = ALU_B;
                end
                ALU_B: if (good) begin
                    addr_d  = ADDR_W'(1);
                    wdata_d = rx_p_data;
                    wr_d    = 1'b1;
                    state_d = ALU_FUN;
                end
                ALU_FUN: if (good) begin
                    fun_d   = rx_p_data[FUN_W-1:0];
                    alu_d   = 1'b1;
                    state_d = ALU_WAIT;
                end
                RD_WAIT: begin
                    err_d = rx_d_valid;
                    if (rf_rd_valid) begin
                        tx_start = 1'b1;
                        state_d  = TX_SEND;
                    end
                end
                ALU_WAIT: begin
                    err_d = rx_d_valid;
                    if (alu_out_valid) begin
                        tx_start = 1'b1;
                        tx_count = 2'd2;
                        tx_word  = alu_out;
                        state_d  = TX_SEND;
                    end
                end
                TX_SEND: begin
                    err_d   = rx_d_valid;
                    state_d = tx_done ? IDLE : TX_SEND;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    uart_resp_tx #(
        .DATA_W(DATA_W)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .count     (tx_count),
        .word      (tx_word),
        .tx_busy   (tx_busy),
        .tx_p_data (tx_p_data),
        .tx_d_valid(tx_d_valid),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: table, random and corner-case checks of the UART command responder
module tb_uart_cmd_responder;

    typedef struct {
        int          nb;
        logic [31:0] bytes;
        int          nw;
        logic [23:0] w;
        int          nt;
        logic [15:0] t;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_p_data = '0;
    logic        rx_d_valid = 1'b0, rx_par_error = 1'b0, rx_framing_error = 1'b0;
    logic [3:0]  rf_addr;
    logic        rf_wr_en, rf_rd_en, alu_en, tx_d_valid, cmd_error;
    logic [7:0]  rf_wr_data, tx_p_data;
    logic [7:0]  rf_rd_data = '0;
    logic        rf_rd_valid = 1'b0;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic        tx_busy;
    logic        resp_busy = 1'b0, hold_busy = 1'b0;

    logic [11:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          err_cnt = 0;
    logic [7:0]  rf_mem [16] = '{default: 8'h00};

    logic [11:0] ew_q[$];
    logic [7:0]  et_q[$];
    int          exp_err = 0;
    logic [7:0]  m [16] = '{default: 8'h00};
    int          ti = 0, wi = 0;
    int          pass_cnt = 0, chk_cnt = 0;
    vec_t        tbl[$];

    assign tx_busy = resp_busy | hold_busy;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .DATA_W(8), .ADDR_W(4), .FUN_W(4), .TIMEOUT(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_p_data       (rx_p_data),
        .rx_d_valid      (rx_d_valid),
        .rx_par_error    (rx_par_error),
        .rx_framing_error(rx_framing_error),
        .rf_addr         (rf_addr),
        .rf_wr_en        (rf_wr_en),
        .rf_wr_data      (rf_wr_data),
        .rf_rd_en        (rf_rd_en),
        .rf_rd_data      (rf_rd_data),
        .rf_rd_valid     (rf_rd_valid),
        .alu_en          (alu_en),
        .alu_fun         (alu_fun),
        .alu_out         (alu_out),
        .alu_out_valid   (alu_out_valid),
        .tx_p_data       (tx_p_data),
        .tx_d_valid      (tx_d_valid),
        .tx_busy         (tx_busy),
        .cmd_error       (cmd_error)
    );

    // environment ALU behaviour: 0 add, 1 multiply, 2 subtract, otherwise {a^fun, b}
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        return f == 4'd0 ? 16'(a) + 16'(b) :
               f == 4'd1 ? 16'(a) * 16'(b) :
               f == 4'd2 ? 16'(a) - 16'(b) : {a ^ {4'h0, f}, b};
    endfunction

    // observe strobes away from the active edge; the register file lives here
    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_q.push_back({rf_addr, rf_wr_data});
            rf_mem[rf_addr] = rf_wr_data;
        end
        if (tx_d_valid) tx_q.push_back(tx_p_data);
        if (cmd_error) err_cnt++;
    end

    // register file read port: data valid one cycle after rf_rd_en
    initial forever begin
        @(negedge clk);
        if (rf_rd_en) begin
            @(posedge clk); #1;
            rf_rd_data = rf_mem[rf_addr];
            rf_rd_valid = 1'b1;
            @(posedge clk); #1;
            rf_rd_valid = 1'b0;
        end
    end

    // ALU: result two cycles after alu_en
    initial forever begin
        @(negedge clk);
        if (alu_en) begin
            repeat (2) @(posedge clk);
            #1;
            alu_out = alu_f(rf_mem[0], rf_mem[1], alu_fun);
            alu_out_valid = 1'b1;
            @(posedge clk); #1;
            alu_out_valid = 1'b0;
        end
    end

    // transmitter: busy for a random 1..4 cycles after each request
    initial forever begin
        @(negedge clk);
        if (tx_d_valid) begin
            @(posedge clk); #1;
            resp_busy = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            resp_busy = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        rx_p_data = b;
        rx_d_valid = 1'b1;
        rx_par_error = pe;
        rx_framing_error = fe;
        @(posedge clk); #1;
        rx_d_valid = 1'b0;
        rx_par_error = 1'b0;
        rx_framing_error = 1'b0;
    endtask

    task automatic settle();
        for (int n = 0; n < 500 && tx_q.size() < et_q.size(); n++) @(negedge clk);
        repeat (12) @(negedge clk);
        check("tx_count", tx_q.size(), et_q.size());
        check("wr_count", wr_q.size(), ew_q.size());
        check("err_count", err_cnt, exp_err);
        for (; ti < et_q.size() && ti < tx_q.size(); ti++) check("tx_byte", 32'(tx_q[ti]), 32'(et_q[ti]));
        for (; wi < ew_q.size() && wi < wr_q.size(); wi++) check("wr_addr_data", 32'(wr_q[wi]), 32'(ew_q[wi]));
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
        ew_q.push_back({a, d});
        m[a] = d;
    endtask

    task automatic expect_alu(input logic [3:0] f);
        logic [15:0] r;
        r = alu_f(m[0], m[1], f);
        et_q.push_back(r[7:0]);
        et_q.push_back(r[15:8]);
    endtask

    initial begin
        logic [7:0] a, d, f, j;
        int         op;
        tbl.push_back('{3, 32'h003C05AA, 1, 24'h00053C, 0, 16'h0000});
        tbl.push_back('{2, 32'h000005BB, 0, 24'h000000, 1, 16'h003C});
        tbl.push_back('{4, 32'h000307CC, 2, 24'h103007, 2, 16'h000A});
        tbl.push_back('{2, 32'h000001DD, 0, 24'h000000, 2, 16'h0015});
        tbl.push_back('{1, 32'h00000055, 0, 24'h000000, 0, 16'h0000});
        tbl.push_back('{3, 32'h00800FAA, 1, 24'h000F80, 0, 16'h0000});
        tbl.push_back('{2, 32'h00001FBB, 0, 24'h000000, 1, 16'h0080});
        tbl.push_back('{2, 32'h000012DD, 0, 24'h000000, 2, 16'h0004});
        tbl.push_back('{4, 32'h020502CC, 2, 24'h105002, 2, 16'hFFFD});
        tbl.push_back('{2, 32'h0000F3DD, 0, 24'h000000, 2, 16'h0105});

        repeat (3) @(negedge clk);
        check("reset_outs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_p_data, tx_d_valid, cmd_error}), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].nb; k++) send(tbl[i].bytes[8*k +: 8]);
            for (int k = 0; k < tbl[i].nw; k++) expect_wr(tbl[i].w[12*k+8 +: 4], tbl[i].w[12*k +: 8]);
            for (int k = 0; k < tbl[i].nt; k++) et_q.push_back(tbl[i].t[8*k +: 8]);
            settle();
        end
        check("alu_fun_last", 32'(alu_fun), 32'h3);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 5);
            a = 8'($urandom);
            d = 8'($urandom);
            f = 8'($urandom);
            case (op)
                0: begin
                    send(8'hAA); send(a); send(d);
                    expect_wr(a[3:0], d);
                end
                1: begin
                    send(8'hBB); send(a);
                    et_q.push_back(m[a[3:0]]);
                end
                2: begin
                    send(8'hCC); send(a); send(d); send(f);
                    expect_wr(4'd0, a);
                    expect_wr(4'd1, d);
                    expect_alu(f[3:0]);
                end
                3: begin
                    send(8'hDD); send(f);
                    expect_alu(f[3:0]);
                end
                4: begin
                    j = 8'($urandom);
                    while (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) j = 8'($urandom);
                    send(j);
                end
                default: begin
                    send(8'hAA); send(a); send(d, f[0], !f[0]);
                    exp_err++;
                end
            endcase
            settle();
        end

        send(8'hAA); send(8'h05); send(8'h11, 1'b1, 1'b0);
        exp_err++;
        send(8'hAA); send(8'h02); send(8'hFF);
        expect_wr(4'd2, 8'hFF);
        settle();

        send(8'hCC, 1'b0, 1'b1);
        send(8'hAA); send(8'h03); send(8'h44);
        expect_wr(4'd3, 8'h44);
        settle();

        hold_busy = 1'b1;
        send(8'hBB); send(8'h01);
        et_q.push_back(m[1]);
        repeat (20) @(posedge clk);
        send(8'h77);
        exp_err++;
        repeat (30) @(negedge clk);
        check("tx_held_off", tx_q.size(), et_q.size() - 1);
        check("err_during_tx", err_cnt, exp_err);
        @(posedge clk); #1;
        hold_busy = 1'b0;
        settle();

        send(8'hAA); send(8'h05);
        repeat (40) @(posedge clk);
        send(8'h3C);
`ifdef UART_CMD_TIMEOUT_EN
        exp_err++;
`else
        expect_wr(4'd5, 8'h3C);
`endif
        settle();

        send(8'hAA); send(8'h06);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("reset_midframe_outs", 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_p_data, tx_d_valid, cmd_error}), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(8'h3C);
        settle();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
